// File: rtl/ysyx_24100012_rf_pkg.sv
// ysyx_24100012_rf_pkg: default register-file geometry and packed-bus slice helpers
package ysyx_24100012_rf_pkg;
    localparam int RF_WIDTH     = 32;
    localparam int RF_N_REG     = 32;
    localparam int RF_INDEX_LEN = 5;

    function automatic int slice_lo(input int k, input int w);
        return k * w;
    endfunction

    function automatic int slice_hi(input int k, input int w);
        return k * w + w - 1;
    endfunction
endpackage

// File: rtl/ysyx_24100012_Reg.sv
// ysyx_24100012_Reg: one storage entry with synchronous clear and write enable
module ysyx_24100012_Reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wen,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata
);
    logic [WIDTH-1:0] r_q;
    always_ff @(posedge clk)
        r_q <= rst ? '0 : (i_wen ? i_wdata : r_q);
    assign o_rdata = r_q;
endmodule

// File: rtl/ysyx_24100012_regfile_mp.sv
// ysyx_24100012_regfile_mp: multi-port register file with write bypass and busy scoreboard
module ysyx_24100012_regfile_mp import ysyx_24100012_rf_pkg::*; #(
    parameter int WIDTH     = RF_WIDTH,
    parameter int N_REG     = RF_N_REG,
    parameter int INDEX_LEN = RF_INDEX_LEN,
    parameter int N_RD      = 2,
    parameter int N_WR      = 2,
    parameter int BYPASS    = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_WR-1:0]           wen,
    input  logic [N_WR*INDEX_LEN-1:0] waddr,
    input  logic [N_WR*WIDTH-1:0]     wdata,
    input  logic [N_RD*INDEX_LEN-1:0] raddr,
    output logic [N_RD*WIDTH-1:0]     rdata,
    output logic [N_RD-1:0]           rbusy,
    input  logic                      alloc_valid,
    input  logic [INDEX_LEN-1:0]      alloc_idx,
    output logic                      alloc_ready
);
    localparam int N_IDX = 1 << INDEX_LEN;

    logic [INDEX_LEN-1:0] w_ra [N_RD];
    logic [INDEX_LEN-1:0] w_wa [N_WR];
    logic [WIDTH-1:0]     w_wdv [N_WR];
    logic [WIDTH-1:0]     w_regs [N_IDX];
    logic [WIDTH-1:0]     w_wd [N_IDX];
    logic [N_IDX-1:0]     w_we;
    logic [N_IDX-1:0]     w_busy;
    logic [N_IDX-1:0]     w_set;
    logic [N_REG-1:0]     r_busy;

    for (genvar k = 0; k < N_RD; k++) begin : g_ra
        assign w_ra[k] = raddr[slice_hi(k, INDEX_LEN):slice_lo(k, INDEX_LEN)];
    end
    for (genvar j = 0; j < N_WR; j++) begin : g_wa
        assign w_wa[j]  = waddr[slice_hi(j, INDEX_LEN):slice_lo(j, INDEX_LEN)];
        assign w_wdv[j] = wdata[slice_hi(j, WIDTH):slice_lo(j, WIDTH)];
    end

    // Ascending port order lets the highest-numbered port win a shared index.
    always_comb begin
        w_we = '0;
        for (int i = 0; i < N_IDX; i++) w_wd[i] = '0;
        for (int j = 0; j < N_WR; j++)
            if (wen[j] && !rst) begin
                w_we[w_wa[j]] = 1'b1;
                w_wd[w_wa[j]] = w_wdv[j];
            end
        for (int i = 0; i < N_IDX; i++)
            if (i == 0 || i >= N_REG) w_we[i] = 1'b0;
    end

    assign w_regs[0] = '0;
    for (genvar i = 1; i < N_IDX; i++) begin : g_reg
        if (i < N_REG) begin : g_st
            ysyx_24100012_Reg #(.WIDTH(WIDTH)) u_reg (
                .clk(clk), .rst(rst), .i_wen(w_we[i]), .i_wdata(w_wd[i]), .o_rdata(w_regs[i])
            );
        end else begin : g_nil
            assign w_regs[i] = '0;
        end
    end

    assign w_busy      = N_IDX'(r_busy);
    assign alloc_ready = alloc_valid && !rst && (!w_busy[alloc_idx] || w_we[alloc_idx]);
    assign w_set       = (alloc_ready && alloc_idx != '0) ? (N_IDX'(1) << alloc_idx) : '0;

    always_comb begin
        rdata = '0;
        rbusy = '0;
        for (int k = 0; k < N_RD; k++) begin
            rdata[slice_lo(k, WIDTH) +: WIDTH] = w_regs[w_ra[k]];
            for (int j = 0; j < N_WR; j++)
                if (BYPASS != 0 && wen[j] && w_we[w_wa[j]] && w_wa[j] == w_ra[k])
                    rdata[slice_lo(k, WIDTH) +: WIDTH] = w_wdv[j];
            rbusy[k] = w_busy[w_ra[k]];
        end
    end

    // Set is applied after clear so a same-cycle allocation keeps the register busy.
    always_ff @(posedge clk)
        r_busy <= rst ? '0 : ((r_busy & ~w_we[N_REG-1:0]) | w_set[N_REG-1:0]);
endmodule

// File: tb/tb_ysyx_24100012_regfile_mp.sv
// tb_ysyx_24100012_regfile_mp: directed checks of bypass and non-bypass register files
module tb_ysyx_24100012_regfile_mp;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  wen;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic [9:0]  raddr;
    logic        alloc_valid;
    logic [4:0]  alloc_idx;
    logic [63:0] rdata, rdata_nb;
    logic [1:0]  rbusy, rbusy_nb;
    logic        alloc_ready, alloc_ready_nb;
    int          n_assert = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    ysyx_24100012_regfile_mp dut (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata), .raddr(raddr),
        .rdata(rdata), .rbusy(rbusy), .alloc_valid(alloc_valid), .alloc_idx(alloc_idx),
        .alloc_ready(alloc_ready)
    );

    ysyx_24100012_regfile_mp #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata), .raddr(raddr),
        .rdata(rdata_nb), .rbusy(rbusy_nb), .alloc_valid(alloc_valid), .alloc_idx(alloc_idx),
        .alloc_ready(alloc_ready_nb)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wen = 2'b00; waddr = '0; wdata = '0; alloc_valid = 1'b0; alloc_idx = '0;
    endtask

    initial begin
        rst = 1'b1; raddr = '0;
        idle();
        step(); step();
        rst = 1'b0;
        raddr = {5'd1, 5'd0}; #1;
        check("reset_rdata", rdata, 64'h0);
        check("reset_rbusy", {62'h0, rbusy}, 64'h0);
        check("reset_ready", {63'h0, alloc_ready}, 64'h0);

        wen = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'h0, 32'hDEADBEEF};
        step(); idle(); raddr = {5'd0, 5'd5}; #1;
        check("x5_written", rdata[31:0], 64'hDEADBEEF);
        rst = 1'b1; wen = 2'b01; waddr = {5'd0, 5'd6}; wdata = {32'h0, 32'h55};
        alloc_valid = 1'b1; alloc_idx = 5'd6; #1;
        check("ready_in_rst", {63'h0, alloc_ready}, 64'h0);
        step(); rst = 1'b0; idle(); raddr = {5'd6, 5'd5}; #1;
        check("x5_after_rst", rdata[31:0], 64'h0);
        check("x6_write_in_rst", rdata[63:32], 64'h0);
        check("rbusy_after_rst", {62'h0, rbusy}, 64'h0);

        wen = 2'b01; waddr = {5'd0, 5'd0}; wdata = {32'h0, 32'h1234}; raddr = '0; #1;
        check("x0_same_cycle", rdata[31:0], 64'h0);
        step(); idle(); #1;
        check("x0_after_edge", rdata[31:0], 64'h0);

        wen = 2'b01; waddr = {5'd0, 5'd7}; wdata = {32'h0, 32'h11111111};
        step();
        wdata = {32'h0, 32'hA5A5A5A5}; raddr = {5'd0, 5'd7}; #1;
        check("bypass_on", rdata[31:0], 64'hA5A5A5A5);
        check("bypass_off_old", rdata_nb[31:0], 64'h11111111);
        step(); idle(); #1;
        check("x7_committed", rdata[31:0], 64'hA5A5A5A5);
        check("x7_committed_nb", rdata_nb[31:0], 64'hA5A5A5A5);

        wen = 2'b11; waddr = {5'd3, 5'd3}; wdata = {32'h22, 32'h11}; raddr = {5'd3, 5'd0}; #1;
        check("conflict_bypass", rdata[63:32], 64'h22);
        step(); idle(); #1;
        check("conflict_store", rdata[63:32], 64'h22);
        check("conflict_store_nb", rdata_nb[63:32], 64'h22);

        alloc_valid = 1'b1; alloc_idx = 5'd9; raddr = {5'd0, 5'd9}; #1;
        check("alloc_ready_free", {63'h0, alloc_ready}, 64'h1);
        check("rbusy_no_bypass", {63'h0, rbusy[0]}, 64'h0);
        step(); #1;
        check("rbusy_set", {63'h0, rbusy[0]}, 64'h1);
        check("alloc_ready_busy", {63'h0, alloc_ready}, 64'h0);
        step(); idle();
        wen = 2'b10; waddr = {5'd9, 5'd0}; wdata = {32'h99, 32'h0}; #1;
        check("busy_until_write", {63'h0, rbusy[0]}, 64'h1);
        step(); idle(); #1;
        check("busy_cleared", {63'h0, rbusy[0]}, 64'h0);
        check("x9_data", rdata[31:0], 64'h99);

        alloc_valid = 1'b1; alloc_idx = 5'd9;
        step();
        wen = 2'b01; waddr = {5'd0, 5'd9}; wdata = {32'h0, 32'hBEEF}; #1;
        check("simul_ready", {63'h0, alloc_ready}, 64'h1);
        step(); idle(); #1;
        check("simul_busy", {63'h0, rbusy[0]}, 64'h1);
        check("simul_data", rdata[31:0], 64'hBEEF);

        alloc_valid = 1'b1; alloc_idx = 5'd0; raddr = {5'd0, 5'd9}; #1;
        check("alloc_x0_ready", {63'h0, alloc_ready}, 64'h1);
        step(); idle(); #1;
        check("alloc_x0_rbusy", {63'h0, rbusy[1]}, 64'h0);
        check("busy_nb_tracks", {62'h0, rbusy_nb}, 64'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/ysyx_24100012_regfile_mp.md
YSYX_24100012_REGFILE_MP -- requirements
Module: ysyx_24100012_regfile_mp

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the data bits per register.
REQ-002 SHALL have parameter N_REG, default 32, giving the register count including x0.
REQ-003 SHALL have parameter INDEX_LEN, default 5, giving the index width in bits, with N_REG <= 2**INDEX_LEN.
REQ-004 SHALL have parameter N_RD, default 2, giving the number of read ports (1..4).
REQ-005 SHALL have parameter N_WR, default 2, giving the number of write ports (1..2).
REQ-006 SHALL have parameter BYPASS, default 1; when 1, same-cycle write data is forwarded to reads.
REQ-007 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-008 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-009 SHALL have port wen, input, N_WR bits: per-port write enable.
REQ-010 SHALL have port waddr, input, N_WR*INDEX_LEN bits: packed write indices, port 0 in the LSBs.
REQ-011 SHALL have port wdata, input, N_WR*WIDTH bits: packed write data.
REQ-012 SHALL have port raddr, input, N_RD*INDEX_LEN bits: packed read indices.
REQ-013 SHALL have port rdata, output, N_RD*WIDTH bits: packed read data.
REQ-014 SHALL have port rbusy, output, N_RD bits: scoreboard busy bit of each read index.
REQ-015 SHALL have port alloc_valid, input, 1 bit: request to mark a destination register busy.
REQ-016 SHALL have port alloc_idx, input, INDEX_LEN bits: the destination to mark busy.
REQ-017 SHALL have port alloc_ready, output, 1 bit: the allocation is accepted this cycle.

Function
REQ-018 SHALL read combinationally: rdata[k] = reg[raddr[k]] at zero latency.
REQ-019 SHALL return 0 on rdata and 0 on rbusy for index 0 and for any index >= N_REG.
REQ-020 SHALL, with BYPASS=1, drive rdata[k] = wdata[j] when wen[j] is high and waddr[j] == raddr[k] != 0 in the same cycle; with BYPASS=0, SHALL return the old value.
REQ-021 SHALL commit writes at the rising clk edge; a write to index 0 or to an index >= N_REG SHALL be ignored.
REQ-022 SHALL resolve two write ports addressing the same register by letting the highest port number win, for both storage and bypass.
REQ-023 SHALL maintain a busy bit per register; busy[0] SHALL be constantly 0.
REQ-024 SHALL raise alloc_ready = alloc_valid && (alloc_idx == 0 || !busy[alloc_idx] || idx being written this cycle); alloc_ready SHALL otherwise be 0.
REQ-025 SHALL set busy[idx] on an accepted allocation to idx != 0; allocation of x0 SHALL be accepted with no effect.
REQ-026 SHALL clear busy[waddr[j]] on each enabled write.
REQ-027 SHALL leave busy[idx] = 1 when a write clears and an allocation sets the same idx in the same cycle (set wins).
REQ-028 SHALL derive rbusy[k] from the registered busy bits, with no bypass of same-cycle alloc or clear.

Reset
REQ-029 SHALL clear every register and every busy bit to 0 on the edge where rst=1; rdata, rbusy and alloc_ready SHALL then read 0 for all indices.
REQ-030 SHALL ignore writes and allocations while rst=1, including those presented mid-operation.

Structure
REQ-031 SHALL place default WIDTH/N_REG/INDEX_LEN values and the packed-slice helper functions in package ysyx_24100012_rf_pkg.
REQ-032 SHALL instantiate one ysyx_24100012_Reg per storage entry 1..N_REG-1 via generate; x0 SHALL be a constant, not a flop.
REQ-033 SHALL keep the scoreboard as a flat N_REG-bit vector in this module.

Verification
REQ-034 SHALL verify reset: write 0xDEADBEEF to x5, assert rst for 1 cycle -> read of x5 = 0 and rbusy = 0.
REQ-035 SHALL verify x0: wen0=1, waddr0=0, wdata0=0x1234 -> rdata for x0 = 0 now and after the edge.
REQ-036 SHALL verify bypass: BYPASS=1, write x7=0xA5A5A5A5 while raddr0=7 -> rdata0 = 0xA5A5A5A5 in the same cycle; with BYPASS=0, the old value is returned.
REQ-037 SHALL verify write conflict: port0 x3=0x11 and port1 x3=0x22 in the same cycle -> x3 = 0x22 afterwards.
REQ-038 SHALL verify scoreboard: alloc x9 -> alloc_ready=1, next cycle rbusy=1; alloc x9 again -> alloc_ready=0; write x9 -> busy clears next cycle.
REQ-039 SHALL verify simultaneous events: write x9 and alloc x9 in the same cycle while busy -> alloc_ready=1, busy stays 1, x9 holds the new data.
